// File: rtl/mul_inner_acc_if.sv
// Port bundle for mul_inner_acc: per-cell command, bit stream and systolic
// random-number pass-through. The cell is the slave; the driver is the master.
interface mul_inner_acc_if #(
    parameter int WIDTH     = 16,
    parameter int CYCLE_LOG = WIDTH - 1
);
    // No backpressure anywhere: i_start is a one-cycle command accepted in any
    // state, and i_en marks i_bit_i valid for the cycle it is high in.
    logic                 i_start;
    logic                 i_en;
    logic                 i_bit_i;
    logic [WIDTH-2:0]     i_data_w;
    logic [WIDTH-2:0]     i_randW;
    logic [WIDTH-2:0]     o_randW;
    logic                 o_bit;
    logic [CYCLE_LOG:0]   o_cnt;
    logic                 o_done;
    logic                 o_busy;

    modport master (
        output i_start, i_en, i_bit_i, i_data_w, i_randW,
        input  o_randW, o_bit, o_cnt, o_done, o_busy
    );

    modport slave (
        input  i_start, i_en, i_bit_i, i_data_w, i_randW,
        output o_randW, o_bit, o_cnt, o_done, o_busy
    );
endinterface

// File: rtl/mul_inner_acc.sv
// Unary-rate multiply-accumulate cell: counts product bits over 2^CYCLE_LOG
// enabled cycles. Define BIPOLAR_EN for XNOR (bipolar) products, else AND.
module mul_inner_acc #(
    parameter int WIDTH     = 16,
    parameter int CYCLE_LOG = WIDTH - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_inner_acc_if.slave       bus,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CYCLE_LOG-1:0] CYC_LAST = '1;
    localparam logic [CYCLE_LOG-1:0] CYC_ONE  = CYCLE_LOG'(1);

    state_e               state_q, state_d;
    logic [WIDTH-2:0]     w_q, w_d;
    logic [WIDTH-2:0]     randw_q;
    logic [CYCLE_LOG-1:0] cyc_q, cyc_d;
    logic [CYCLE_LOG:0]   cnt_q, cnt_d;

    logic bit_w;
    logic prod_bit;
    logic mul_bit;

    // Weight-to-bit conversion uses the registered random number so that the
    // compare lines up with the value this cell forwards downstream.
    assign bit_w = (w_q > randw_q);

`ifdef BIPOLAR_EN
    assign prod_bit = ~(bus.i_bit_i ^ bit_w);
`else
    assign prod_bit = bus.i_bit_i & bit_w;
`endif

    assign mul_bit = (state_q == ST_RUN) && bus.i_en && prod_bit;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        // A start restarts the window from any state, overriding a final bit.
        if (bus.i_start) begin
            state_d = ST_RUN;
            w_d     = bus.i_data_w;
            cyc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (bus.i_en) begin
                        cnt_d = cnt_q + (CYCLE_LOG+1)'(mul_bit);
                        cyc_d = cyc_q + CYC_ONE;
                        if (cyc_q == CYC_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            randw_q <= '0;
            cyc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            randw_q <= bus.i_randW;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_randW = randw_q;
    assign bus.o_bit   = mul_bit;
    assign bus.o_cnt   = cnt_q;
    assign bus.o_done  = (state_q == ST_DONE);
    assign bus.o_busy  = (state_q == ST_RUN);
    assign dbg_state_o = state_q;

endmodule
